stack_host_ctrl: RTL and testbench
==================================

Name: stack_host_ctrl

Overview:
Initiator side of the 8-bit push/pop stack interface. It takes push/pop commands from an on-chip requester through a valid/ready handshake and drives the stack's push, pop and bidirectional data pins. It waits for the stack's done handshake and returns popped bytes or error status. It keeps a shadow occupancy count so it never issues an overflowing push or underflowing pop.

Parameters:
DEPTH, 16, stack capacity in bytes; also the shadow counter limit.
CNT_W, 5, shadow counter width; must hold 0..DEPTH inclusive.
TIMEOUT, 15, cycles allowed in each wait state before aborting.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  reset; asynchronous, active-low.
cmd_valid  input  1  requester has a command.
cmd_op  input  1  command type: 1=push, 0=pop.
cmd_data  input  8  byte to push; ignored for pop.
cmd_ready  output  1  controller is IDLE and can accept a command.
rsp_valid  output  1  one-cycle pulse when a command completes.
rsp_data  output  8  popped byte; 0 for push and for errors.
rsp_err  output  2  status: 00=ok, 01=overflow, 10=underflow, 11=timeout.
stk_push  output  1  push strobe to the stack.
stk_pop  output  1  pop strobe to the stack.
stk_data_out  output  8  data driven toward the stack.
stk_data_oe  output  8  per-bit output enable for stk_data_out; all 1s or all 0s.
stk_data_in  input  8  data read from the stack.
stk_done  input  1  stack status: high=idle/complete, low=busy.
level  output  CNT_W  shadow occupancy count.
full  output  1  asserted when level == DEPTH.
empty  output  1  asserted when level == 0.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, level=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, stk_push=0, stk_pop=0, stk_data_out=0, stk_data_oe=0, timer=0. Reset mid-transaction aborts with no response.
- All outputs are registered. The combinational exceptions are cmd_ready, full and empty, which decode directly from state or level.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready=1; a command is accepted when cmd_valid & cmd_ready; cmd_op and cmd_data are latched.
  - Push with full=1, or pop with empty=1: go straight to RESP with err 01 or 10; no stack pins toggle.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - stk_push or stk_pop is high for exactly this cycle.
  - Push: stk_data_out=latched byte and stk_data_oe=FF, both held until WAIT_DONE exits.
  - Pop: stk_data_oe=00.
  - Next state: WAIT_ACK.
- WAIT_ACK: wait for stk_done==0 (stack busy), then go to WAIT_DONE and clear the timer.
- WAIT_DONE: wait for stk_done==1, then go to RESP.
  - Pop: rsp_data captures stk_data_in in the same cycle stk_done is sampled high.
  - Push: level+1. Pop: level-1.
- Timeout: in WAIT_ACK or WAIT_DONE, the timer increments each cycle. When timer==TIMEOUT, go to RESP with err 11, rsp_data=0, level unchanged, and stk_data_oe dropped to 00.
- RESP (one cycle): rsp_valid=1 with rsp_data and rsp_err; stk_data_oe=00; return to IDLE. rsp_data and rsp_err hold until the next response.
- Minimum command-to-response latency on a successful stack transaction: 4 cycles after acceptance (ISSUE, WAIT_ACK, WAIT_DONE, RESP), assuming the stack drops done one cycle after the strobe and raises it one cycle later. Error responses arrive 1 cycle after acceptance.
- cmd_ready=0 in every state except IDLE; there is no command queuing.
- stk_push and stk_pop are never high together, and never outside ISSUE.
- level saturates in range by construction. An implementation must still never wrap it past DEPTH or below 0.

Test Plan:
- Push 0xA5 to a bench stack model that drops done one cycle after the strobe → stk_push high exactly one cycle, stk_data_oe=FF with data A5 until done rises, rsp_valid with err 00, level=1.
- Push 0x11, 0x22, 0x33, then pop three times → rsp_data sequence 0x33, 0x22, 0x11 with err 00; level returns to 0 and empty=1.
- Pop at reset (empty) → rsp_valid one cycle after acceptance with err 10 and rsp_data 0; stk_pop never asserts.
- Push 16 bytes, then push a 17th → full=1 after the 16th; the 17th gives err 01 with no stk_push pulse; level stays 16.
- Model never drops stk_done → rsp_err=11 after TIMEOUT+1 cycles in WAIT_ACK, stk_data_oe returns to 00, level unchanged, cmd_ready returns to 1.
- Assert rst_n low while in WAIT_DONE during a push → all outputs go to reset values immediately without waiting for clk; no rsp_valid; level=0; the next command is accepted normally.

Source files
------------

// File: rtl/stack_host_ctrl.sv
// Initiator for an 8-bit push/pop stack: accepts requester commands, runs the strobe/done
// handshake on the stack pins and keeps a shadow occupancy count to block over/underflow.
module stack_host_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic             cmd_op,
  input  logic [7:0]       cmd_data,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic [1:0]       rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [7:0]       stk_data_out,
  output logic [7:0]       stk_data_oe,
  input  logic [7:0]       stk_data_in,
  input  logic             stk_done,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned TimerW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ErrOk        = 2'b00;
  localparam logic [1:0] ErrOverflow  = 2'b01;
  localparam logic [1:0] ErrUnderflow = 2'b10;
  localparam logic [1:0] ErrTimeout   = 2'b11;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitAck, StWaitDone, StResp} state_e;

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]    level_q, level_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                stk_push_q, stk_push_d;
  logic                stk_pop_q, stk_pop_d;
  logic [7:0]          stk_data_out_q, stk_data_out_d;
  logic [7:0]          stk_data_oe_q, stk_data_oe_d;
  logic                timed_out;

  assign timed_out = (timer_q == TimerW'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    timer_d        = timer_q;
    level_d        = level_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    stk_push_d     = 1'b0;
    stk_pop_d      = 1'b0;
    stk_data_out_d = stk_data_out_q;
    stk_data_oe_d  = stk_data_oe_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op && full) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_err_d   = ErrOverflow;
          end else if (!cmd_op && empty) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_err_d   = ErrUnderflow;
          end else begin
            // Strobes are registered, so raising them here makes them high during StIssue.
            state_d = StIssue;
            if (cmd_op) begin
              stk_push_d     = 1'b1;
              stk_data_out_d = cmd_data;
              stk_data_oe_d  = 8'hFF;
            end else begin
              stk_pop_d     = 1'b1;
              stk_data_oe_d = 8'h00;
            end
          end
        end
      end
      StIssue: begin
        state_d = StWaitAck;
        timer_d = '0;
      end
      StWaitAck: begin
        if (!stk_done) begin
          state_d = StWaitDone;
          timer_d = '0;
        end else if (timed_out) begin
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_data_d     = 8'h00;
          rsp_err_d      = ErrTimeout;
          stk_data_oe_d  = 8'h00;
          stk_data_out_d = 8'h00;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitDone: begin
        if (stk_done) begin
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_err_d      = ErrOk;
          stk_data_oe_d  = 8'h00;
          stk_data_out_d = 8'h00;
          if (op_q) begin
            rsp_data_d = 8'h00;
            if (level_q < CNT_W'(DEPTH)) level_d = level_q + CNT_W'(1);
          end else begin
            rsp_data_d = stk_data_in;
            if (level_q != '0) level_d = level_q - CNT_W'(1);
          end
        end else if (timed_out) begin
          state_d        = StResp;
          rsp_valid_d    = 1'b1;
          rsp_data_d     = 8'h00;
          rsp_err_d      = ErrTimeout;
          stk_data_oe_d  = 8'h00;
          stk_data_out_d = 8'h00;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      op_q           <= 1'b0;
      timer_q        <= '0;
      level_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'h00;
      rsp_err_q      <= ErrOk;
      stk_push_q     <= 1'b0;
      stk_pop_q      <= 1'b0;
      stk_data_out_q <= 8'h00;
      stk_data_oe_q  <= 8'h00;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      timer_q        <= timer_d;
      level_q        <= level_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      stk_push_q     <= stk_push_d;
      stk_pop_q      <= stk_pop_d;
      stk_data_out_q <= stk_data_out_d;
      stk_data_oe_q  <= stk_data_oe_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign full         = (level_q == CNT_W'(DEPTH));
  assign empty        = (level_q == '0);
  assign level        = level_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign stk_push     = stk_push_q;
  assign stk_pop      = stk_pop_q;
  assign stk_data_out = stk_data_out_q;
  assign stk_data_oe  = stk_data_oe_q;

endmodule

// File: tb/tb_stack_host_ctrl.sv
// Directed bench for stack_host_ctrl with a small behavioural stack on the far side.
module tb_stack_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_out;
  logic [7:0] stk_data_oe;
  logic [7:0] stk_data_in = 8'hEE;
  logic       stk_done = 1'b1;
  logic [4:0] level;
  logic       full;
  logic       empty;

  stack_host_ctrl #(.DEPTH(16), .CNT_W(5), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_out (stk_data_out),
    .stk_data_oe  (stk_data_oe),
    .stk_data_in  (stk_data_in),
    .stk_done     (stk_done),
    .level        (level),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stack model: done drops at the strobe, stays low two sampling edges, then rises with data.
  logic [7:0] mem [0:31];
  int  sp = 0;
  int  ph = 0;
  logic hang = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; sp = 0; stk_done = 1'b1; stk_data_in = 8'hEE;
    end else begin
      case (ph)
        0: begin
          stk_data_in = 8'hEE;
          if ((stk_push || stk_pop) && !hang) begin
            if (stk_push) begin mem[sp] = stk_data_out; sp++; end
            else sp--;
            stk_done = 1'b0;
            ph = 1;
          end
        end
        1: ph = 2;
        default: begin
          stk_done = 1'b1;
          stk_data_in = mem[sp];
          ph = 0;
        end
      endcase
    end
  end

  int push_cnt = 0, pop_cnt = 0, both_cnt = 0, rsp_cnt = 0, oe_a5_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_push) push_cnt++;
      if (stk_pop) pop_cnt++;
      if (stk_push && stk_pop) both_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (stk_data_oe == 8'hFF && stk_data_out == 8'hA5) oe_a5_cnt++;
    end
  end

  // lat counts negedges from acceptance to the first sample showing rsp_valid.
  task automatic do_cmd(input logic op, input logic [7:0] d,
                        output logic [7:0] rd, output logic [1:0] re, output int lat);
    @(negedge clk);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    if (!rsp_valid) check("rsp_wait_bound", 32'd0, 32'd1);
    rd = rsp_data;
    re = rsp_err;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rd;
  logic [1:0] re;
  int lat, pc, rc;
  logic [7:0] exp_pop [0:2];

  initial begin
    exp_pop[0] = 8'h33; exp_pop[1] = 8'h22; exp_pop[2] = 8'h11;
    apply_reset();
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_oe", {24'd0, stk_data_oe}, 32'd0);

    // Pop while empty: immediate underflow, no pop strobe.
    pc = pop_cnt;
    do_cmd(1'b0, 8'h00, rd, re, lat);
    check("uf_err", {30'd0, re}, 32'd2);
    check("uf_data", {24'd0, rd}, 32'd0);
    check("uf_lat", lat, 32'd1);
    check("uf_no_pop", pop_cnt - pc, 32'd0);

    // Single push of A5.
    pc = push_cnt;
    do_cmd(1'b1, 8'hA5, rd, re, lat);
    check("pa5_err", {30'd0, re}, 32'd0);
    check("pa5_lat", lat, 32'd4);
    check("pa5_strobe", push_cnt - pc, 32'd1);
    check("pa5_oe_cycles", oe_a5_cnt, 32'd3);
    check("pa5_oe_after", {24'd0, stk_data_oe}, 32'd0);
    check("pa5_level", {27'd0, level}, 32'd1);
    @(negedge clk);
    check("pa5_ready_again", {31'd0, cmd_ready}, 32'd1);
    check("pa5_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    do_cmd(1'b0, 8'h00, rd, re, lat);
    check("pa5_pop_data", {24'd0, rd}, 32'hA5);
    check("pa5_pop_lat", lat, 32'd4);

    // LIFO ordering.
    do_cmd(1'b1, 8'h11, rd, re, lat);
    do_cmd(1'b1, 8'h22, rd, re, lat);
    do_cmd(1'b1, 8'h33, rd, re, lat);
    check("lifo_level3", {27'd0, level}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, 8'h00, rd, re, lat);
      check("lifo_data", {24'd0, rd}, {24'd0, exp_pop[i]});
      check("lifo_err", {30'd0, re}, 32'd0);
    end
    check("lifo_level0", {27'd0, level}, 32'd0);
    check("lifo_empty", {31'd0, empty}, 32'd1);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 16; i++) begin
      do_cmd(1'b1, 8'(i + 1), rd, re, lat);
      if (i == 14) check("fill_not_full", {31'd0, full}, 32'd0);
    end
    check("fill_level", {27'd0, level}, 32'd16);
    check("fill_full", {31'd0, full}, 32'd1);
    pc = push_cnt;
    do_cmd(1'b1, 8'hFE, rd, re, lat);
    check("of_err", {30'd0, re}, 32'd1);
    check("of_lat", lat, 32'd1);
    check("of_no_push", push_cnt - pc, 32'd0);
    check("of_level", {27'd0, level}, 32'd16);
    do_cmd(1'b0, 8'h00, rd, re, lat);
    check("of_top", {24'd0, rd}, 32'h10);

    // Stack never answers: timeout after TIMEOUT+1 cycles in WAIT_ACK.
    apply_reset();
    hang = 1'b1;
    do_cmd(1'b1, 8'h5A, rd, re, lat);
    check("to_err", {30'd0, re}, 32'd3);
    check("to_data", {24'd0, rd}, 32'd0);
    check("to_lat", lat, 32'd18);
    check("to_oe", {24'd0, stk_data_oe}, 32'd0);
    check("to_level", {27'd0, level}, 32'd0);
    hang = 1'b0;
    @(negedge clk);
    check("to_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset asserted mid-push while in WAIT_DONE.
    do_cmd(1'b1, 8'h44, rd, re, lat);
    check("pre_rst_level", {27'd0, level}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 8'hC3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rc = rsp_cnt;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_oe", {24'd0, stk_data_oe}, 32'hFF);
    rst_n = 1'b0;
    #1;
    check("arst_oe", {24'd0, stk_data_oe}, 32'd0);
    check("arst_dout", {24'd0, stk_data_out}, 32'd0);
    check("arst_level", {27'd0, level}, 32'd0);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_rsp", rsp_cnt - rc, 32'd0);
    do_cmd(1'b1, 8'h77, rd, re, lat);
    check("post_rst_err", {30'd0, re}, 32'd0);
    check("post_rst_lat", lat, 32'd4);
    check("post_rst_level", {27'd0, level}, 32'd1);
    do_cmd(1'b0, 8'h00, rd, re, lat);
    check("post_rst_pop", {24'd0, rd}, 32'h77);

    check("push_pop_overlap", both_cnt, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
